axi4_ram_slave: RTL

AXI4 responder backed by on-chip block RAM, the slave-side counterpart of the SoC's 32-bit AXI4 master port. It decodes AW/W/B and AR/R channels with 4-bit IDs, 8-bit burst lengths and FIXED/INCR/WRAP bursts, and services them from a single-port word-wide RAM. It is used as a DDR stand-in for bring-up and simulation, and as a scratch memory behind the interconnect.

---
 rtl/axi4_ram_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_ram_slave.sv
// axi4_ram_slave: AXI4 responder backed by a single-port, word-wide RAM.
// One transaction in flight at a time. Handles FIXED, INCR and WRAP bursts.
// Optional feature: define AXI_RAM_DECERR_EN so that beats outside the RAM window
// return DECERR (2'b11). Without it, such addresses alias modulo the RAM size.
module axi4_ram_slave #(
    parameter int unsigned RAM_ADDR_W = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inport_awvalid_i,
    output logic        inport_awready_o,
    input  logic [31:0] inport_awaddr_i,
    input  logic [3:0]  inport_awid_i,
    input  logic [7:0]  inport_awlen_i,
    input  logic [1:0]  inport_awburst_i,
    input  logic        inport_wvalid_i,
    output logic        inport_wready_o,
    input  logic [31:0] inport_wdata_i,
    input  logic [3:0]  inport_wstrb_i,
    input  logic        inport_wlast_i,
    output logic        inport_bvalid_o,
    input  logic        inport_bready_i,
    output logic [1:0]  inport_bresp_o,
    output logic [3:0]  inport_bid_o,
    input  logic        inport_arvalid_i,
    output logic        inport_arready_o,
    input  logic [31:0] inport_araddr_i,
    input  logic [3:0]  inport_arid_i,
    input  logic [7:0]  inport_arlen_i,
    input  logic [1:0]  inport_arburst_i,
    output logic        inport_rvalid_o,
    input  logic        inport_rready_i,
    output logic [31:0] inport_rdata_o,
    output logic [1:0]  inport_rresp_o,
    output logic [3:0]  inport_rid_o,
    output logic        inport_rlast_o
);
    localparam int unsigned RamWords = 2 ** RAM_ADDR_W;
    localparam logic [29:0] BaseWord = BASE_ADDR[31:2];

    typedef enum logic [1:0] {StIdle, StWrite, StWresp, StRead} state_e;

    state_e      state_q, state_d;
    logic        grant_wr_q;  // 1: the last grant went to the write channel
    logic [29:0] addr_q;      // word address of the current beat
    logic [3:0]  id_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic [1:0]  burst_q;
    logic        err_q;       // some beat of the current write was out of range
    logic        rerr_q;      // beat held in ram_rdata was out of range
    logic [31:0] ram [RamWords];
    logic [31:0] ram_rdata;

    logic        aw_hs, ar_hs, w_hs, r_hs, last_beat, rd_en;
    logic        wr_oor, rd_oor;
    logic [29:0] next_addr, rd_word;
    logic        unused_bits;

    // Word address of the following beat for the given burst type.
    function automatic logic [29:0] step_addr(input logic [29:0] w, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [29:0] inc;
        logic [29:0] mask;
        inc  = w + 30'd1;
        mask = {22'd0, len};
        case (burst)
            2'b00: step_addr = w;
            2'b10: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
                    step_addr = (w & ~mask) | (inc & mask);
                end else begin
                    step_addr = inc;
                end
            end
            default: step_addr = inc;
        endcase
    endfunction

    function automatic logic [RAM_ADDR_W-1:0] ram_index(input logic [29:0] w);
        logic [29:0] off;
        off = w - BaseWord;
        return off[RAM_ADDR_W-1:0];
    endfunction

`ifdef AXI_RAM_DECERR_EN
    function automatic logic in_window(input logic [29:0] w);
        logic [32:0] a, lo, hi;
        a  = {1'b0, w, 2'b00};
        lo = {1'b0, BASE_ADDR};
        hi = lo + (33'd1 << (RAM_ADDR_W + 2));
        return (a >= lo) && (a < hi);
    endfunction
    assign wr_oor = !in_window(addr_q);
    assign rd_oor = !in_window(rd_word);
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    assign aw_hs     = inport_awvalid_i && inport_awready_o;
    assign ar_hs     = inport_arvalid_i && inport_arready_o;
    assign w_hs      = inport_wvalid_i && inport_wready_o;
    assign r_hs      = inport_rvalid_o && inport_rready_i;
    assign last_beat = (cnt_q == len_q);
    assign next_addr = step_addr(addr_q, len_q, burst_q);
    // The RAM is addressed from araddr on the AR handshake so beat 0 is ready next cycle;
    // afterwards it prefetches the next beat only when the current one is accepted.
    assign rd_word   = ar_hs ? inport_araddr_i[31:2] : next_addr;
    assign rd_en     = ar_hs || (r_hs && !last_beat);

    assign inport_bresp_o = err_q ? 2'b11 : 2'b00;
    assign inport_bid_o   = id_q;
    assign inport_rid_o   = id_q;
    assign inport_rlast_o = (state_q == StRead) && last_beat;
    assign inport_rresp_o = ((state_q == StRead) && rerr_q) ? 2'b11 : 2'b00;
    assign inport_rdata_o = ((state_q == StRead) && !rerr_q) ? ram_rdata : 32'd0;

    assign unused_bits = ^{inport_wlast_i, inport_awaddr_i[1:0], inport_araddr_i[1:0]};

    // Arbitration, channel handshakes and next-state decode.
    always_comb begin
        state_d          = state_q;
        inport_awready_o = 1'b0;
        inport_arready_o = 1'b0;
        inport_wready_o  = 1'b0;
        inport_bvalid_o  = 1'b0;
        inport_rvalid_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // On a tie the channel not granted last time wins.
                if (inport_awvalid_i && (!inport_arvalid_i || !grant_wr_q)) begin
                    inport_awready_o = 1'b1;
                    state_d          = StWrite;
                end else if (inport_arvalid_i) begin
                    inport_arready_o = 1'b1;
                    state_d          = StRead;
                end
            end
            StWrite: begin
                inport_wready_o = 1'b1;
                // Burst length comes from awlen; wlast is not consulted.
                if (inport_wvalid_i && last_beat) state_d = StWresp;
            end
            StWresp: begin
                inport_bvalid_o = 1'b1;
                if (inport_bready_i) state_d = StIdle;
            end
            StRead: begin
                inport_rvalid_o = 1'b1;
                if (inport_rready_i && last_beat) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, captured request fields, beat counter and response flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            grant_wr_q <= 1'b0;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                grant_wr_q <= 1'b1;
                addr_q     <= inport_awaddr_i[31:2];
                id_q       <= inport_awid_i;
                len_q      <= inport_awlen_i;
                burst_q    <= inport_awburst_i;
                cnt_q      <= '0;
                err_q      <= 1'b0;
            end else if (ar_hs) begin
                grant_wr_q <= 1'b0;
                addr_q     <= inport_araddr_i[31:2];
                id_q       <= inport_arid_i;
                len_q      <= inport_arlen_i;
                burst_q    <= inport_arburst_i;
                cnt_q      <= '0;
            end else if (w_hs || r_hs) begin
                addr_q <= next_addr;
                cnt_q  <= cnt_q + 8'd1;
                if (w_hs && wr_oor) err_q <= 1'b1;
            end
            if (rd_en) rerr_q <= rd_oor;
        end
    end

    // Single-port RAM: byte-enabled writes, registered reads; no reset on contents.
    always_ff @(posedge clk_i) begin
        if (w_hs && !wr_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (inport_wstrb_i[b]) begin
                    ram[ram_index(addr_q)][8*b +: 8] <= inport_wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en) ram_rdata <= ram[ram_index(rd_word)];
    end

endmodule
